// File: rtl/rr_credit_tagger_if.sv
// ----------------------------------------------------------------------------
// rr_credit_tagger_if
// Beat-level stream bundle used on both sides of the round-robin credit
// tagger.
//
// Parameters
//   DATA_WIDTH  width of a data beat
//   KEEP_WIDTH  width of the keep mask
//
// Signals
//   data   beat payload                        (source -> sink)
//   keep   byte keep mask                      (source -> sink)
//   last   final beat of a packet              (source -> sink)
//   valid  beat present                        (source -> sink)
//   ready  sink can take the beat this cycle   (sink -> source)
//
// Modports
//   master  the side that produces beats
//   slave   the side that consumes beats
// ----------------------------------------------------------------------------
interface rr_credit_tagger_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic                  valid;
    logic                  ready;

    modport master (
        output data,
        output keep,
        output last,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  keep,
        input  last,
        input  valid,
        output ready
    );
endinterface

// File: rtl/rr_credit_tagger.sv
// ----------------------------------------------------------------------------
// rr_credit_tagger
// Upstream stage of the tagged crossbar. Takes one untagged packet stream and
// stamps every beat with a destination tag. A destination is chosen once per
// packet, round-robin over the destinations that still hold credits. Each
// destination owns a credit counter, so no crossbar output ever has more
// packets in flight than its consumer can absorb.
//
// Parameters
//   DATA_WIDTH        width of a data beat
//   KEEP_WIDTH        width of the keep mask
//   NUM_DESTS         number of destinations (>= 2)
//   TAG_WIDTH         width of out_tag, $clog2(NUM_DESTS)
//   CREDITS_PER_DEST  packets allowed in flight per destination (>= 1)
//
// Ports
//   clk            clock
//   rst            synchronous, active-high reset
//   in_bus         untagged input stream (slave side)
//   out_bus        registered output stream (master side)
//   out_tag        destination of the beat presented on out_bus
//   credit_return  one-cycle pulse per bit: destination d finished a packet
//   credit_err     sticky: a credit came back while its counter was full
//   stat_pkts      (RR_TAGGER_STATS_EN only) packets started, wrapping
//   stat_stalls    (RR_TAGGER_STATS_EN only) idle cycles blocked on credits,
//                  saturating
//
// Optional feature
//   Define RR_TAGGER_STATS_EN to add the stat_pkts / stat_stalls counters.
//   Without it the ports and counters do not exist; core behaviour is the
//   same either way.
// ----------------------------------------------------------------------------
module rr_credit_tagger #(
    parameter int DATA_WIDTH       = 64,
    parameter int KEEP_WIDTH       = 8,
    parameter int NUM_DESTS        = 4,
    parameter int TAG_WIDTH        = $clog2(NUM_DESTS),
    parameter int CREDITS_PER_DEST = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_credit_tagger_if.slave     in_bus,
    rr_credit_tagger_if.master    out_bus,
    output logic [TAG_WIDTH-1:0]  out_tag,
    input  logic [NUM_DESTS-1:0]  credit_return,
    output logic                  credit_err
`ifdef RR_TAGGER_STATS_EN
    ,
    output logic [31:0]           stat_pkts,
    output logic [31:0]           stat_stalls
`endif
);

    localparam int                  CW         = $clog2(CREDITS_PER_DEST + 1);
    localparam logic [CW-1:0]       CREDIT_MAX = CW'(CREDITS_PER_DEST);
    localparam logic [TAG_WIDTH-1:0] LAST_DEST = TAG_WIDTH'(NUM_DESTS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [NUM_DESTS-1:0][CW-1:0] credit_q;
    logic [TAG_WIDTH-1:0]         rr_ptr_q;
    logic [TAG_WIDTH-1:0]         tag_q;

    logic [TAG_WIDTH:0]           cand_sum;
    logic [TAG_WIDTH-1:0]         cand_idx;
    logic [TAG_WIDTH-1:0]         pick_idx;
    logic                         pick_found;

    logic                         in_ready;
    logic                         accept;
    logic                         pkt_start;
    logic                         load_en;
    logic [TAG_WIDTH-1:0]         beat_tag;
    logic [NUM_DESTS-1:0]         consume;

    logic [DATA_WIDTH-1:0]        data_q;
    logic [KEEP_WIDTH-1:0]        keep_q;
    logic                         last_q;
    logic                         valid_q;
    logic [TAG_WIDTH-1:0]         out_tag_q;

    // Round-robin search starting at rr_ptr over the registered credits.
    // The candidate index is formed one bit wider so the wrap back to zero
    // is a single subtract, which also works when NUM_DESTS is not a power
    // of two.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_DESTS; i++) begin
            cand_sum = {1'b0, rr_ptr_q} + (TAG_WIDTH + 1)'(i);
            if (cand_sum >= (TAG_WIDTH + 1)'(NUM_DESTS)) begin
                cand_sum = cand_sum - (TAG_WIDTH + 1)'(NUM_DESTS);
            end
            cand_idx = cand_sum[TAG_WIDTH-1:0];
            if (!pick_found && (credit_q[cand_idx] != '0)) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Handshake and packet FSM. Credits only gate the first beat of a
    // packet; once a packet is in BUSY it runs to its last beat on tag_q.
    always_comb begin
        state_d   = state_q;
        load_en   = !valid_q || out_bus.ready;
        in_ready  = load_en && ((state_q == BUSY) || pick_found);
        accept    = in_bus.valid && in_ready;
        pkt_start = accept && (state_q == IDLE);
        beat_tag  = (state_q == IDLE) ? pick_idx : tag_q;
        case (state_q)
            IDLE: begin
                if (accept && !in_bus.last) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept && in_bus.last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Packet tag and round-robin pointer advance only at packet start.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q    <= '0;
            rr_ptr_q <= '0;
        end else if (pkt_start) begin
            tag_q    <= pick_idx;
            rr_ptr_q <= (pick_idx == LAST_DEST) ? '0 : pick_idx + TAG_WIDTH'(1);
        end
    end

    // Single output register. When it cannot load (full and stalled) every
    // out_* field holds; when it loads without a new beat it just empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
            out_tag_q <= '0;
        end else if (load_en) begin
            valid_q <= accept;
            if (accept) begin
                data_q    <= in_bus.data;
                keep_q    <= in_bus.keep;
                last_q    <= in_bus.last;
                out_tag_q <= beat_tag;
            end
        end
    end

    always_comb begin
        consume = '0;
        for (int d = 0; d < NUM_DESTS; d++) begin
            consume[d] = pkt_start && (pick_idx == TAG_WIDTH'(d));
        end
    end

    // Per-destination credit counters. A return and a consume in the same
    // cycle cancel. A return into a full counter is a protocol error from
    // downstream: the count saturates and the sticky error flag is raised.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q   <= {NUM_DESTS{CREDIT_MAX}};
            credit_err <= 1'b0;
        end else begin
            for (int d = 0; d < NUM_DESTS; d++) begin
                case ({credit_return[d], consume[d]})
                    2'b10: begin
                        if (credit_q[d] == CREDIT_MAX) begin
                            credit_err <= 1'b1;
                        end else begin
                            credit_q[d] <= credit_q[d] + CW'(1);
                        end
                    end
                    2'b01: begin
                        credit_q[d] <= credit_q[d] - CW'(1);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // The arbiter only ever picks a destination with a non-zero count, so a
    // consume from an empty counter would mean the arbiter is broken.
    for (genvar g = 0; g < NUM_DESTS; g++) begin : g_underflow_chk
        a_no_underflow : assert property (
            @(posedge clk) disable iff (rst) consume[g] |-> (credit_q[g] != '0)
        );
    end

    assign in_bus.ready  = in_ready;
    assign out_bus.data  = data_q;
    assign out_bus.keep  = keep_q;
    assign out_bus.last  = last_q;
    assign out_bus.valid = valid_q;
    assign out_tag       = out_tag_q;

`ifdef RR_TAGGER_STATS_EN
    // Packet counter wraps naturally; stall counter sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkts   <= '0;
            stat_stalls <= '0;
        end else begin
            if (pkt_start) begin
                stat_pkts <= stat_pkts + 32'd1;
            end
            if (in_bus.valid && (state_q == IDLE) && !pick_found &&
                (stat_stalls != 32'hFFFF_FFFF)) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rr_credit_tagger.sv
// ----------------------------------------------------------------------------
// tb_rr_credit_tagger
// Directed bench for rr_credit_tagger (NUM_DESTS=4, CREDITS_PER_DEST=2).
// Stimulus pushes the hand-computed expected beat into a queue when the
// input handshake happens; an independent monitor pops and compares each
// beat that leaves on the output handshake.
// ----------------------------------------------------------------------------
module tb_rr_credit_tagger;

    localparam int DATA_WIDTH = 64;
    localparam int KEEP_WIDTH = 8;
    localparam int NUM_DESTS  = 4;
    localparam int TAG_WIDTH  = 2;
    localparam int CREDITS    = 2;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [TAG_WIDTH-1:0]  tag;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [TAG_WIDTH-1:0] out_tag;
    logic [NUM_DESTS-1:0] credit_return;
    logic                 credit_err;

    int    checks   = 0;
    int    failures = 0;
    beat_t exp_q[$];
    beat_t mon_exp;
    logic [127:0] snap;

    rr_credit_tagger_if #(.DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH)) in_bus ();
    rr_credit_tagger_if #(.DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH)) out_bus ();

`ifdef RR_TAGGER_STATS_EN
    logic [31:0] stat_pkts;
    logic [31:0] stat_stalls;
`endif

    rr_credit_tagger #(
        .DATA_WIDTH       (DATA_WIDTH),
        .KEEP_WIDTH       (KEEP_WIDTH),
        .NUM_DESTS        (NUM_DESTS),
        .TAG_WIDTH        (TAG_WIDTH),
        .CREDITS_PER_DEST (CREDITS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_bus        (in_bus),
        .out_bus       (out_bus),
        .out_tag       (out_tag),
        .credit_return (credit_return),
        .credit_err    (credit_err)
`ifdef RR_TAGGER_STATS_EN
        ,
        .stat_pkts     (stat_pkts),
        .stat_stalls   (stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    // Present one beat and hold it until accepted; the expected output beat
    // is queued at the handshake. Returns at posedge+1 after acceptance.
    task automatic applyStimulus(input logic [DATA_WIDTH-1:0] data,
                                 input logic [KEEP_WIDTH-1:0] keep,
                                 input logic last,
                                 input logic [TAG_WIDTH-1:0] exp_tag);
        beat_t b;
        bit    done;
        done         = 1'b0;
        b.data       = data;
        b.keep       = keep;
        b.last       = last;
        b.tag        = exp_tag;
        in_bus.data  = data;
        in_bus.keep  = keep;
        in_bus.last  = last;
        in_bus.valid = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (in_bus.ready) begin
                exp_q.push_back(b);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: got no accept, want accept of %0h", data);
        end
        in_bus.valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
            @(negedge clk);
        end
        checkOutput("queue_drained", 128'(exp_q.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst           = 1'b1;
        in_bus.valid  = 1'b0;
        credit_return = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Output monitor: every output handshake must match the next queued beat.
    initial begin
        forever begin
            @(negedge clk);
            if (out_bus.valid && out_bus.ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_beat: got data %0h tag %0d, want none",
                             out_bus.data, out_tag);
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("out_beat",
                                {out_bus.data, out_bus.keep, out_bus.last, out_tag},
                                mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        in_bus.data   = '0;
        in_bus.keep   = '0;
        in_bus.last   = 1'b0;
        in_bus.valid  = 1'b0;
        out_bus.ready = 1'b1;
        credit_return = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_out_valid", 128'(out_bus.valid), 128'd0);
        checkOutput("rst_out_data", 128'(out_bus.data), 128'd0);
        checkOutput("rst_out_tag", 128'(out_tag), 128'd0);
        checkOutput("rst_out_last", 128'(out_bus.last), 128'd0);
        checkOutput("rst_credit_err", 128'(credit_err), 128'd0);
        checkOutput("rst_in_ready", 128'(in_bus.ready), 128'd1);
        for (int d = 0; d < NUM_DESTS; d++) begin
            checkOutput("rst_credit", 128'(dut.credit_q[d]), 128'd2);
        end
        @(posedge clk);
        #1;

        // Four single-beat packets back to back: tags 0..3
        $display("[TB] four single-beat packets");
        applyStimulus(64'hA000_0000_0000_0001, 8'hFF, 1'b1, 2'd0);
        checkOutput("first_latency_valid", 128'(out_bus.valid), 128'd1);
        applyStimulus(64'hA000_0000_0000_0002, 8'h0F, 1'b1, 2'd1);
        applyStimulus(64'hA000_0000_0000_0003, 8'h01, 1'b1, 2'd2);
        applyStimulus(64'hA000_0000_0000_0004, 8'h80, 1'b1, 2'd3);
        waitDrain();
        doReset();

        // Three-beat packet then a single-beat packet
        $display("[TB] multi-beat packet");
        applyStimulus(64'hB000_0000_0000_0001, 8'hFF, 1'b0, 2'd0);
        applyStimulus(64'hB000_0000_0000_0002, 8'hFF, 1'b0, 2'd0);
        applyStimulus(64'hB000_0000_0000_0003, 8'h3F, 1'b1, 2'd0);
        checkOutput("mb_credit0", 128'(dut.credit_q[0]), 128'd1);
        applyStimulus(64'hB000_0000_0000_0004, 8'h07, 1'b1, 2'd1);
        checkOutput("mb_credit0_again", 128'(dut.credit_q[0]), 128'd1);
        checkOutput("mb_credit1", 128'(dut.credit_q[1]), 128'd1);
        waitDrain();
        doReset();

        // Exhaust all credits, then free destination 2
        $display("[TB] credit exhaustion");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(64'hC000_0000_0000_0000 + 64'(i), 8'hFF, 1'b1, 2'(i % 4));
        end
        in_bus.data  = 64'hC000_0000_0000_0009;
        in_bus.keep  = 8'hAA;
        in_bus.last  = 1'b1;
        in_bus.valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("no_credit_in_ready", 128'(in_bus.ready), 128'd0);
        end
        @(posedge clk);
        #1;
        credit_return = 4'b0100;
        @(posedge clk);
        #1;
        credit_return = '0;
        checkOutput("ready_after_return", 128'(in_bus.ready), 128'd1);
        applyStimulus(64'hC000_0000_0000_0009, 8'hAA, 1'b1, 2'd2);
        checkOutput("ninth_tag_now", 128'(out_tag), 128'd2);
        checkOutput("credit2_used", 128'(dut.credit_q[2]), 128'd0);
        waitDrain();
        doReset();

        // Downstream stall for five cycles while input keeps offering beats
        $display("[TB] downstream stall");
        out_bus.ready = 1'b0;
        fork
            begin
                applyStimulus(64'hD000_0000_0000_0001, 8'h11, 1'b1, 2'd0);
                applyStimulus(64'hD000_0000_0000_0002, 8'h22, 1'b1, 2'd1);
                applyStimulus(64'hD000_0000_0000_0003, 8'h33, 1'b1, 2'd2);
            end
            begin
                for (int c = 0; c < 10 && !out_bus.valid; c++) begin
                    @(negedge clk);
                end
                snap = 128'({out_bus.valid, out_bus.data, out_bus.keep, out_bus.last, out_tag});
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("stall_hold",
                                128'({out_bus.valid, out_bus.data, out_bus.keep,
                                      out_bus.last, out_tag}),
                                snap);
                    checkOutput("stall_in_ready", 128'(in_bus.ready), 128'd0);
                end
                @(posedge clk);
                #1;
                out_bus.ready = 1'b1;
            end
        join
        waitDrain();
        doReset();

        // Same-cycle return and consume; return into a full counter
        $display("[TB] credit return corner cases");
        applyStimulus(64'hE000_0000_0000_0001, 8'hFF, 1'b1, 2'd0);
        credit_return = 4'b0010;
        applyStimulus(64'hE000_0000_0000_0002, 8'hFF, 1'b1, 2'd1);
        credit_return = '0;
        @(negedge clk);
        checkOutput("same_cycle_credit1", 128'(dut.credit_q[1]), 128'd2);
        checkOutput("no_err_yet", 128'(credit_err), 128'd0);
        @(posedge clk);
        #1;
        credit_return = 4'b1000;
        @(posedge clk);
        #1;
        credit_return = '0;
        checkOutput("err_set", 128'(credit_err), 128'd1);
        checkOutput("credit3_saturated", 128'(dut.credit_q[3]), 128'd2);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("err_sticky", 128'(credit_err), 128'd1);
        waitDrain();
        doReset();
        checkOutput("err_cleared", 128'(credit_err), 128'd0);

        // Reset in the middle of a four-beat packet
        $display("[TB] reset mid-packet");
        applyStimulus(64'hF000_0000_0000_0001, 8'hFF, 1'b0, 2'd0);
        in_bus.data  = 64'hF000_0000_0000_0002;
        in_bus.keep  = 8'hFF;
        in_bus.last  = 1'b0;
        in_bus.valid = 1'b1;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        in_bus.valid = 1'b0;
        checkOutput("mid_rst_out_valid", 128'(out_bus.valid), 128'd0);
        for (int d = 0; d < NUM_DESTS; d++) begin
            checkOutput("mid_rst_credit", 128'(dut.credit_q[d]), 128'd2);
        end
        applyStimulus(64'hF000_0000_0000_0010, 8'h0F, 1'b1, 2'd0);
        checkOutput("post_rst_credit0", 128'(dut.credit_q[0]), 128'd1);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
